rf_port_arb: RTL and testbench
==============================

// Module: rf_port_arb
// PURPOSE
//  Shares register-file port A (single R/W port, async read) between N_REQ requesters
//  using round-robin arbitration with a valid/ready handshake.
//  After reset, sequences a clear of all RF entries to zero (the RF has no reset) before
//  serving requests. Sits between the RF and its client blocks; port B is untouched.
// PARAMETERS
//  N_REQ   4  number of requesters (2..8)
//  ADDR_W  4  RF address width; DEPTH = 2**ADDR_W entries
//  DATA_W  8  RF data width
// PORTS
//  clk            in   1               clock, all state on posedge
//  rst_n          in   1               async reset, active low
//  req_valid      in   N_REQ           per-requester request valid
//  req_we         in   N_REQ           1 = write, 0 = read
//  req_addr       in   N_REQ*ADDR_W    packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata      in   N_REQ*DATA_W    packed, requester i at [i*DATA_W +: DATA_W]
//  req_ready      out  N_REQ           one-hot grant; transfer when valid&ready
//  rsp_valid      out  N_REQ           one-cycle pulse: read data for requester i
//  rsp_data       out  DATA_W          read data, valid when any rsp_valid bit set
//  init_done      out  1               RF clear complete, arbitration active
//  rf_port_A      out  ADDR_W          to RF port A address
//  rf_port_A_in   out  DATA_W          to RF port A write data
//  rf_port_A_we   out  1               to RF port A write enable
//  rf_port_A_out  in   DATA_W          from RF port A read data (combinational)
// BEHAVIOUR
//  Reset values: state=WAIT, clr_addr=0, rr_ptr=0, rsp_valid=0, rsp_data=0, init_done=0.
//  FSM: WAIT -> CLEAR (unconditional, 1 cycle) ; CLEAR -> RUN when clr_addr==DEPTH-1 ;
//   RUN stays RUN until rst_n low.
//  WAIT: req_ready=0, rf_port_A_we=0, rf_port_A=0, rf_port_A_in=0.
//  CLEAR: rf_port_A=clr_addr, rf_port_A_in=0, rf_port_A_we=1, req_ready=0;
//   clr_addr increments each cycle. DEPTH writes total.
//  init_done registered high from the (DEPTH+1)th posedge after rst_n deasserts (17 @ default).
//  RUN arbitration (combinational, same cycle):
//   - search req_valid starting at rr_ptr, wrapping modulo N_REQ; first set bit = g.
//   - req_ready = one-hot(g); zero if no req_valid bit set. req_ready never depends on
//     a requester's own we/addr.
//   - on grant: rf_port_A=req_addr[g], rf_port_A_in=req_wdata[g], rf_port_A_we=req_we[g].
//   - no grant: rf_port_A=0, rf_port_A_in=0, rf_port_A_we=0; rr_ptr holds.
//   - after grant: rr_ptr <= (g+1) mod N_REQ (grant winner becomes lowest priority).
//  Read response: on granted read, rsp_data <= rf_port_A_out and rsp_valid[g] <= 1 at
//   the same edge; rsp_valid is exactly 1 cycle wide (latency 1). On granted write or
//   idle cycle, rsp_valid <= 0; rsp_data holds last value.
//  Write then read of same address on consecutive cycles returns the new data.
//  Requesters may hold req_valid indefinitely; fairness: any continuously valid
//   requester is granted within N_REQ cycles.
//  req_valid asserted during WAIT/CLEAR is not granted and not lost (held by requester).
//  rst_n low mid-operation: immediate return to WAIT, all outputs to reset values,
//   in-flight response dropped; full RF clear repeats after release.
// STRUCTURE
//  Package rf_arb_pkg: state enum {WAIT, CLEAR, RUN}; localparams for default widths.
//  Sub-module rf_rr_pick: combinational round-robin picker
//   (in: req vector, ptr; out: one-hot grant, grant index, any_grant).
//  Top holds FSM, clr_addr counter, rr_ptr, response registers, RF-port muxing.
// TESTING
//  1 Preload RF with 0xFF (force via hierarchy), release rst_n -> 16 writes of 0 to
//    addr 0..15 in order, init_done high on 17th edge, all reads return 0x00.
//  2 Req0 write addr 3 = 0xA5, next cycle req0 read addr 3 -> rsp_valid=4'b0001
//    one cycle later, rsp_data=0xA5.
//  3 All four req_valid held high, reads of addr i -> req_ready sequence 0001,0010,0100,
//    1000,0001; rsp_valid follows one cycle behind in same order.
//  4 rr_ptr=2 with req1 and req3 valid -> req3 granted first, then req1.
//  5 Assert rst_n low mid-read burst -> rsp_valid, req_ready, init_done drop at once;
//    after release, clear repeats and earlier 0xA5 at addr 3 reads as 0x00.
//  6 req_valid high during CLEAR -> req_ready stays 0 until init_done, then granted.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file port A arbiter.
//   arb_state_e : sequencer states (WAIT -> CLEAR -> RUN)
//   *_DEF       : default parameter values used by rf_port_arb
package rf_arb_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,  // one idle cycle after reset release
    CLEAR = 2'd1,  // writing zero to every RF entry
    RUN   = 2'd2   // round-robin arbitration of port A
  } arb_state_e;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rf_rr_pick.sv
// Combinational round-robin picker.
//   req       in  : request vector
//   ptr       in  : highest-priority index for this cycle
//   grant     out : one-hot grant (zero when nothing requested)
//   grant_idx out : index of the granted requester
//   any_grant out : at least one request present
module rf_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  always_comb begin
    int               j;
    logic [IDX_W-1:0] cand;
    j         = 0;
    cand      = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    // Walk from the lowest priority back to ptr so the last hit is the winner.
    for (int k = N - 1; k >= 0; k--) begin
      j    = (int'(ptr) + k) % N;
      cand = IDX_W'(j);
      if (req[cand]) begin
        grant_idx = cand;
        any_grant = 1'b1;
      end
    end
    grant = any_grant ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/rf_port_arb.sv
// Register-file port A arbiter.
// After reset it clears every RF entry to zero, then shares the single R/W
// port between N_REQ requesters with round-robin priority.
//   req_valid/req_we/req_addr/req_wdata in : packed per-requester requests
//   req_ready     out : one-hot grant, transfer on valid & ready
//   rsp_valid     out : one-cycle read-data pulse for the requester
//   rsp_data      out : read data, held between reads
//   init_done     out : RF clear finished, arbitration active
//   rf_port_A*        : address / write data / write enable / async read data
module rf_port_arb
  import rf_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    init_done,
  output logic [ADDR_W-1:0]       rf_port_A,
  output logic [DATA_W-1:0]       rf_port_A_in,
  output logic                    rf_port_A_we,
  input  logic [DATA_W-1:0]       rf_port_A_out
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int DEPTH = 2 ** ADDR_W;

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              init_done_q, init_done_d;

  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  rf_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_grant (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    req_ready    = '0;
    rf_port_A    = '0;
    rf_port_A_in = '0;
    rf_port_A_we = 1'b0;
    case (state_q)
      WAIT: state_d = CLEAR;
      CLEAR: begin
        rf_port_A    = clr_addr_q;
        rf_port_A_we = 1'b1;
        clr_addr_d   = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (pick_any) begin
          req_ready    = pick_grant;
          rf_port_A    = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          rf_port_A_in = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          rf_port_A_we = req_we[pick_idx];
          // Winner drops to lowest priority.
          rr_ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          // Async RF read: capture the data in the same cycle as the grant.
          if (!req_we[pick_idx]) begin
            rsp_valid_d = pick_grant;
            rsp_data_d  = rf_port_A_out;
          end
        end
      end
      default: state_d = WAIT;
    endcase
    init_done_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT;
      clr_addr_q  <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_port_arb.sv
// Self-checking bench for rf_port_arb with an attached behavioural RF,
// a reference model of arbitration/memory and a response scoreboard.
module tb_rf_port_arb;

  localparam int N     = 4;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            init_done;
  logic [AW-1:0]   rf_port_A;
  logic [DW-1:0]   rf_port_A_in;
  logic            rf_port_A_we;
  logic [DW-1:0]   rf_port_A_out;

  rf_port_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .init_done     (init_done),
    .rf_port_A     (rf_port_A),
    .rf_port_A_in  (rf_port_A_in),
    .rf_port_A_we  (rf_port_A_we),
    .rf_port_A_out (rf_port_A_out)
  );

  always #5 clk = ~clk;

  // Behavioural register file: no reset, async read, preload to 0xFF on demand.
  logic          preload = 1'b1;
  logic [DW-1:0] rf [DEPTH];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= 8'hFF;
    end else if (rf_port_A_we) begin
      rf[rf_port_A] <= rf_port_A_in;
    end
  end
  assign rf_port_A_out = rf[rf_port_A];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input longint act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: observed 0x%0h (t=%0t)", name, act, $time);
  endtask

  // Free-running cycle count and edges since reset release.
  int cyc   = 0;
  int edges = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else if (edges < 1000) edges <= edges + 1;
  end

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] last_data;
  int            next_prio;
  int            g_m;
  int            a_m;
  exp_t          e_m;

  // Scoreboard (responses) followed by the reference model (grants, RF port).
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      next_prio = 0;
      last_data = '0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_req_ready", req_ready, 0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        flag("rsp_missing", exp_q[0].idx);
        void'(exp_q.pop_front());
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          flag("rsp_unexpected", rsp_valid);
        end else begin
          e_m = exp_q.pop_front();
          chk("rsp_valid", rsp_valid, 1 << e_m.idx);
          last_data = e_m.data;
          $display("rsp  cyc=%0d req=%0d data=0x%02h", cyc, e_m.idx, rsp_data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        flag("rsp_missing", exp_q[0].idx);
        void'(exp_q.pop_front());
      end
      chk("rsp_data", rsp_data, last_data);

      chk("init_done", init_done, (edges >= DEPTH + 1) ? 1 : 0);
      if (edges < DEPTH + 1) begin
        // WAIT for one cycle, then one zero write per address in order.
        chk("init_ready", req_ready, 0);
        chk("init_we", rf_port_A_we, (edges != 0) ? 1 : 0);
        chk("init_addr", rf_port_A, (edges != 0) ? edges - 1 : 0);
        chk("init_wdata", rf_port_A_in, 0);
      end else begin
        g_m = -1;
        for (int k = 0; k < N; k++) begin
          if (g_m < 0 && req_valid[(next_prio + k) % N]) g_m = (next_prio + k) % N;
        end
        if (g_m < 0) begin
          chk("idle_ready", req_ready, 0);
          chk("idle_we", rf_port_A_we, 0);
        end else begin
          a_m = int'(req_addr[g_m*AW +: AW]);
          chk("grant", req_ready, 1 << g_m);
          chk("port_addr", rf_port_A, a_m);
          chk("port_we", rf_port_A_we, req_we[g_m]);
          if (req_we[g_m]) begin
            chk("port_wdata", rf_port_A_in, req_wdata[g_m*DW +: DW]);
            mem_m[a_m] = req_wdata[g_m*DW +: DW];
            $display("wr   cyc=%0d req=%0d addr=%0d data=0x%02h", cyc, g_m, a_m, mem_m[a_m]);
          end else begin
            e_m.idx  = g_m;
            e_m.data = mem_m[a_m];
            e_m.due  = cyc + 1;
            exp_q.push_back(e_m);
            $display("rd   cyc=%0d req=%0d addr=%0d", cyc, g_m, a_m);
          end
          next_prio = (g_m + 1) % N;
        end
      end
    end
  end

  // One cycle: sample grant at negedge, return just after the next posedge.
  task automatic step(output logic [N-1:0] g);
    @(negedge clk);
    g = req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input int addr, input int data);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = AW'(addr);
    req_wdata[i*DW +: DW]  = DW'(data);
  endtask

  task automatic wait_init();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (init_done) seen = 1'b1;
    end
    if (!seen) flag("init_timeout", init_done);
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] g;

  initial begin
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_init();

    // All four requesters reading addr i; pointer starts at 0.
    for (int i = 0; i < N; i++) set_req(i, 1, 0, i, 0);
    for (int k = 0; k < 5; k++) begin
      step(g);
      chk("rr_sequence", g, 1 << (k % N));
    end
    req_valid = '0;

    // Every address reads back as cleared.
    for (int a = 0; a < DEPTH; a++) begin
      set_req(2, 1, 0, a, 0);
      step(g);
      chk("clear_read_grant", g, 4'b0100);
    end
    req_valid = '0;

    // Move the pointer to 2, then req1 and req3 contend.
    set_req(1, 1, 0, 5, 0);
    step(g);
    chk("ptr_setup_grant", g, 4'b0010);
    set_req(3, 1, 0, 6, 0);
    step(g);
    chk("ptr2_first", g, 4'b1000);
    step(g);
    chk("ptr2_second", g, 4'b0010);
    req_valid = '0;

    // Write then read the same address on consecutive cycles.
    set_req(0, 1, 1, 3, 8'hA5);
    step(g);
    chk("wr_grant", g, 4'b0001);
    set_req(0, 1, 0, 3, 0);
    step(g);
    req_valid = '0;
    @(negedge clk);
    chk("wr_rd_valid", rsp_valid, 4'b0001);
    chk("wr_rd_data", rsp_data, 8'hA5);
    @(posedge clk);
    #1;

    // Random traffic with held requests.
    for (int c = 0; c < 400; c++) begin
      step(g);
      for (int i = 0; i < N; i++) begin
        if (g[i] || !req_valid[i])
          set_req(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 255));
      end
    end
    req_valid = '0;
    step(g);

    // Reset in the middle of a read burst.
    set_req(0, 1, 1, 3, 8'hA5);
    step(g);
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 3, 0);
    repeat (3) step(g);
    chk("pre_reset_rsp", (rsp_valid != '0) ? 1 : 0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_req_ready", req_ready, 0);
    chk("async_init_done", init_done, 0);
    req_valid = '0;
    set_req(0, 1, 0, 3, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Request held through the clear is granted on the first RUN cycle.
    begin
      bit done;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (init_done) begin
          chk("held_grant", req_ready, 4'b0001);
          done = 1'b1;
        end else begin
          chk("held_blocked", req_ready, 0);
        end
        @(posedge clk);
        #1;
      end
      if (!done) flag("held_timeout", init_done);
    end
    req_valid = '0;
    @(negedge clk);
    chk("after_reset_valid", rsp_valid, 4'b0001);
    chk("after_reset_data", rsp_data, 8'h00);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
